// File: rtl/branch_resolve_ctrl_if.sv
// Shared types and the decode/fetch-facing bundle of the branch resolution
// controller. The package holds the branch condition encoding used by decode.

package rv32_pkg;
  // Branch condition codes. Codes 6 and 7 are reserved and never resolve taken.
  typedef enum logic [2:0] {
    COMP_EQ   = 3'd0,
    COMP_NE   = 3'd1,
    COMP_LT   = 3'd2,
    COMP_GE   = 3'd3,
    COMP_LTU  = 3'd4,
    COMP_GEU  = 3'd5,
    COMP_RSV6 = 3'd6,
    COMP_RSV7 = 3'd7
  } rv32_compop;
endpackage

// Descriptor, flag, redirect and status signals between the pipeline
// (master side) and the branch resolution controller (slave side).
interface branch_resolve_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import rv32_pkg::*;

  // descriptor from decode
  logic             i_req_valid;
  logic             o_req_ready;
  rv32_compop       i_req_compop;
  logic             i_req_uncond;
  logic             i_req_pred_taken;
  logic [XLEN-1:0]  i_req_target;
  logic [XLEN-1:0]  i_req_pc_next;

  // ALU flag word {V,C,Z,N}
  logic             i_flags_valid;
  logic [3:0]       i_flags;

  // redirect to fetch
  logic             o_redirect_valid;
  logic             i_redirect_ready;
  logic [XLEN-1:0]  o_redirect_pc;

  // pipeline control and status
  logic             o_flush;
  logic             o_resolved;
  logic             o_taken;
  logic [CNT_W-1:0] o_mispredict_cnt;

  modport master (
    output i_req_valid, i_req_compop, i_req_uncond, i_req_pred_taken,
           i_req_target, i_req_pc_next, i_flags_valid, i_flags,
           i_redirect_ready,
    input  o_req_ready, o_redirect_valid, o_redirect_pc, o_flush,
           o_resolved, o_taken, o_mispredict_cnt
  );

  modport slave (
    input  i_req_valid, i_req_compop, i_req_uncond, i_req_pred_taken,
           i_req_target, i_req_pc_next, i_flags_valid, i_flags,
           i_redirect_ready,
    output o_req_ready, o_redirect_valid, o_redirect_pc, o_flush,
           o_resolved, o_taken, o_mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution sequencer for the execute stage. Takes one
// descriptor at a time, evaluates its condition against the ALU flags,
// redirects fetch on a misprediction, then holds a flush for a fixed number
// of cycles. Also maintains a saturating mispredict counter.

// Evaluates a branch condition from the ALU flag word {V,C,Z,N}.
// Carry follows the "set means no borrow" convention, so C=1 means a >= b unsigned.
module comparison_unit
  import rv32_pkg::*;
(
  input  rv32_compop compop,
  input  logic [3:0] flags,
  output logic       taken
);
  logic flag_v;
  logic flag_c;
  logic flag_z;
  logic flag_n;

  assign flag_v = flags[3];
  assign flag_c = flags[2];
  assign flag_z = flags[1];
  assign flag_n = flags[0];

  // Condition decode; reserved codes fall through to not-taken.
  always_comb begin
    taken = 1'b0;
    case (compop)
      COMP_EQ:  taken = flag_z;
      COMP_NE:  taken = ~flag_z;
      COMP_LT:  taken = flag_n ^ flag_v;
      COMP_GE:  taken = ~(flag_n ^ flag_v);
      COMP_LTU: taken = ~flag_c;
      COMP_GEU: taken = flag_c;
      default:  taken = 1'b0;
    endcase
  end
endmodule

module branch_resolve_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  branch_resolve_ctrl_if.slave  bus
);

  // Flush down-counter only needs to hold FLUSH_CYCLES-1; keep at least one bit
  // so FLUSH_CYCLES of 0..2 still produce a legal vector.
  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_REDIRECT   = 2'd2,
    S_FLUSH      = 2'd3
  } state_t;

  state_t           state_reg,       state_next;
  rv32_compop       compop_reg,      compop_next;
  logic             uncond_reg,      uncond_next;
  logic             pred_taken_reg,  pred_taken_next;
  logic [XLEN-1:0]  target_reg,      target_next;
  logic [XLEN-1:0]  pc_next_reg,     pc_next_next;
  logic [XLEN-1:0]  redirect_pc_reg, redirect_pc_next;
  logic [FCW-1:0]   flush_cnt_reg,   flush_cnt_next;
  logic             resolved_reg,    resolved_next;
  logic             taken_reg,       taken_next;
  logic [CNT_W-1:0] cnt_reg,         cnt_next;

  // Resolution event of the current cycle, shared by both resolve paths.
  logic             resolve;
  logic             res_taken;
  logic             res_pred;
  logic [XLEN-1:0]  res_target;
  logic [XLEN-1:0]  res_pc_next;

  logic             cmp_taken;

  comparison_unit u_cmp (
    .compop (compop_reg),
    .flags  (bus.i_flags),
    .taken  (cmp_taken)
  );

  // State register and all datapath registers; reset drops any in-flight work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= S_IDLE;
      compop_reg      <= COMP_EQ;
      uncond_reg      <= 1'b0;
      pred_taken_reg  <= 1'b0;
      target_reg      <= '0;
      pc_next_reg     <= '0;
      redirect_pc_reg <= '0;
      flush_cnt_reg   <= '0;
      resolved_reg    <= 1'b0;
      taken_reg       <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      compop_reg      <= compop_next;
      uncond_reg      <= uncond_next;
      pred_taken_reg  <= pred_taken_next;
      target_reg      <= target_next;
      pc_next_reg     <= pc_next_next;
      redirect_pc_reg <= redirect_pc_next;
      flush_cnt_reg   <= flush_cnt_next;
      resolved_reg    <= resolved_next;
      taken_reg       <= taken_next;
      cnt_reg         <= cnt_next;
    end
  end

  // Next-state logic: accept, resolve, redirect handshake and flush countdown.
  always_comb begin
    state_next       = state_reg;
    compop_next      = compop_reg;
    uncond_next      = uncond_reg;
    pred_taken_next  = pred_taken_reg;
    target_next      = target_reg;
    pc_next_next     = pc_next_reg;
    redirect_pc_next = redirect_pc_reg;
    flush_cnt_next   = flush_cnt_reg;
    resolved_next    = 1'b0;
    taken_next       = 1'b0;
    cnt_next         = cnt_reg;

    resolve     = 1'b0;
    res_taken   = 1'b0;
    res_pred    = 1'b0;
    res_target  = target_reg;
    res_pc_next = pc_next_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          compop_next     = bus.i_req_compop;
          uncond_next     = bus.i_req_uncond;
          pred_taken_next = bus.i_req_pred_taken;
          target_next     = bus.i_req_target;
          pc_next_next    = bus.i_req_pc_next;
          if (bus.i_req_uncond) begin
            // Jumps need no flags: resolve taken in the accept cycle straight
            // from the incoming descriptor.
            resolve     = 1'b1;
            res_taken   = 1'b1;
            res_pred    = bus.i_req_pred_taken;
            res_target  = bus.i_req_target;
            res_pc_next = bus.i_req_pc_next;
            state_next  = bus.i_req_pred_taken ? S_IDLE : S_REDIRECT;
          end else begin
            state_next = S_WAIT_FLAGS;
          end
        end
      end

      S_WAIT_FLAGS: begin
        if (bus.i_flags_valid) begin
          resolve    = 1'b1;
          res_taken  = uncond_reg | cmp_taken;
          res_pred   = pred_taken_reg;
          state_next = (res_taken == pred_taken_reg) ? S_IDLE : S_REDIRECT;
        end
      end

      S_REDIRECT: begin
        if (bus.i_redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            flush_cnt_next = FLUSH_LOAD;
            state_next     = S_FLUSH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Resolution side effects: status pulse, redirect target, mispredict count.
    if (resolve) begin
      resolved_next    = 1'b1;
      taken_next       = res_taken;
      redirect_pc_next = res_taken ? res_target : res_pc_next;
      if ((res_taken != res_pred) && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Handshake and flush outputs decode straight from state, so nothing
  // combinational leaks from the request inputs to o_req_ready.
  assign bus.o_req_ready      = (state_reg == S_IDLE);
  assign bus.o_redirect_valid = (state_reg == S_REDIRECT);
  assign bus.o_flush          = (state_reg == S_FLUSH);
  assign bus.o_redirect_pc    = redirect_pc_reg;
  assign bus.o_resolved       = resolved_reg;
  assign bus.o_taken          = taken_reg;
  assign bus.o_mispredict_cnt = cnt_reg;

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences branch and jump resolution in the FRI-V execute stage. Accepts one control-transfer descriptor at a time from decode, waits for the ALU flag word, and evaluates the condition with an internal `comparison_unit` instance. On a misprediction it issues a PC redirect to fetch, then holds a pipeline flush for a fixed number of cycles. It also keeps a saturating misprediction counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, address width
- FLUSH_CYCLES, 2, cycles `o_flush` is held after a redirect handshake (0 allowed)
- CNT_W, 16, mispredict counter width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  branch/jump descriptor valid
- o_req_ready  out  1  controller idle, can accept a descriptor
- i_req_compop  in  rv32_compop  branch condition
- i_req_uncond  in  1  JAL/JALR, always taken, no flags needed
- i_req_pred_taken  in  1  fetch prediction for this instruction
- i_req_target  in  XLEN  taken target
- i_req_pc_next  in  XLEN  fall-through PC (pc+4)
- i_flags_valid  in  1  ALU flags valid for the pending branch
- i_flags  in  4  {V,C,Z,N}
- o_redirect_valid  out  1  redirect request to fetch
- i_redirect_ready  in  1  fetch accepts redirect
- o_redirect_pc  out  XLEN  redirect PC, stable while `o_redirect_valid` is high
- o_flush  out  1  kill younger in-flight instructions
- o_resolved  out  1  one-cycle pulse, a descriptor was resolved
- o_taken  out  1  resolved outcome, valid with `o_resolved`
- o_mispredict_cnt  out  CNT_W  saturating mispredict count

## Operation
- FSM states:
  - IDLE: `o_req_ready`=1.
  - WAIT_FLAGS.
  - REDIRECT.
  - FLUSH: uses down-counter `flush_cnt`.
- Accept happens on `i_req_valid && o_req_ready`. On accept, register compop, uncond, pred_taken, target and pc_next.
- Unconditional accept:
  - taken=1 and resolution happens in the accept cycle.
  - If `pred_taken`=1, next state is IDLE; otherwise REDIRECT.
- Conditional accept: next state is WAIT_FLAGS.
- WAIT_FLAGS:
  - Flags are sampled only in this state. `i_flags_valid` in any other state is ignored, including the accept cycle.
  - When `i_flags_valid`=1: taken = `comparison_unit(i_flags, stored compop)`. An undefined compop gives taken=0.
  - If taken == pred_taken, next state is IDLE; otherwise REDIRECT.
- Redirect PC is registered at resolution: target if taken, else pc_next.
- REDIRECT:
  - `o_redirect_valid`=1, and PC is held until `i_redirect_ready`.
  - On the handshake: if FLUSH_CYCLES>0, load `flush_cnt`=FLUSH_CYCLES-1 and go to FLUSH; else go to IDLE.
- FLUSH:
  - `o_flush`=1.
  - When `flush_cnt`==0, go to IDLE; else decrement.
- `o_resolved` and `o_taken` are registered: a one-cycle pulse in the cycle after resolution.
- `o_mispredict_cnt` increments by 1 in the cycle after each mispredicting resolution and saturates at 2^CNT_W-1.
- Only one descriptor is in flight; no queuing.
- Reset, asynchronous, at any point including mid-REDIRECT or mid-FLUSH:
  - State goes to IDLE; counter, pulses, redirect and flush all go to 0; `o_redirect_pc`=0.
  - A pending descriptor is discarded and no redirect is issued.

## Timing
- Reset values:
  - `o_req_ready`=1.
  - `o_redirect_valid`, `o_flush`, `o_resolved`, `o_taken`=0.
  - `o_redirect_pc`=0, `o_mispredict_cnt`=0.
- Conditional branch, accepted cycle 0, flags valid at cycle k≥1:
  - Resolution at cycle k; `o_resolved` at k+1.
  - Correct prediction: `o_req_ready`=1 again at k+1.
  - Mispredict: `o_redirect_valid` from k+1 until the handshake cycle r.
  - `o_flush` in cycles r+1 .. r+FLUSH_CYCLES.
  - `o_req_ready`=1 at r+FLUSH_CYCLES+1 (r+1 if FLUSH_CYCLES=0).
- Unconditional, accepted cycle 0: `o_resolved`=1 at cycle 1. If mispredicted, `o_redirect_valid` from cycle 1.
- Redirect ready asserted in the first REDIRECT cycle gives r = k+1 (single-cycle redirect).
- `o_req_ready` is a pure decode of state; no combinational path from `i_req_valid`.

## Test plan
- BEQ: compop=eq, pred_taken=0, target=0x100, flags Z=1 at cycle 2 -> `o_resolved`/`o_taken`=1 at cycle 3; `o_redirect_pc`=0x100 valid from cycle 3; ready held → `o_flush` cycles 4-5; `o_req_ready` at 6; count=1.
- BLTU: pred_taken=0, flags C=1 -> taken=0, no redirect, `o_req_ready`=1 the cycle after flags; count unchanged.
- BLT: flags N=1, V=0, pred_taken=1 -> taken=1, no redirect. With flags N=1, V=1 and pred_taken=1 -> redirect to pc_next.
- JAL: uncond=1, pred_taken=0, target=0x2000 -> redirect 0x2000 valid at cycle 1; hold `i_redirect_ready`=0 for 3 cycles -> PC stable, no flush until after the handshake.
- Backpressure and stray inputs: `i_req_valid` held during WAIT_FLAGS -> not accepted. `i_flags_valid` in IDLE -> ignored.
- Reset mid-FLUSH -> all outputs to reset values immediately; next request handled normally. Force 2^CNT_W mispredicts -> counter holds at all-ones.
